// File: rtl/instr_encoder.sv
// RV32I instruction encoder: assembles a 32-bit word from decoded fields and
// streams it into sequential instruction-memory word addresses.
module instr_encoder #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        op,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic              funct7b5,
    input  logic [12:0]       imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              err,
    output logic              full,
    output logic [ADDR_W:0]   count
);

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_S  = 7'b0100011;
    localparam logic [6:0] OP_B  = 7'b1100011;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] TOP  = '1;

    typedef enum logic {
        ST_LOADING,
        ST_FULL
    } state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] ptr, ptr_next;
    logic [ADDR_W-1:0] addr_next;
    logic [ADDR_W:0]   count_next;
    logic [31:0]       wdata_next;
    logic              we_next, err_next;
    logic [31:0]       enc;
    logic              bad, is_shift, imm_ovf, accept;

    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
    // The 13-bit immediate only fits a 12-bit field when bits 12 and 11 agree.
    assign imm_ovf  = imm[12] ^ imm[11];

    // NOTE: every signal written here gets a default first, so no path infers a latch.
    always_comb begin
        enc = '0;
        bad = 1'b0;
        case (op)
            OP_R: enc = {1'b0, funct7b5, 5'b0, rs2, rs1, funct3, rd, op};
            OP_I: begin
                if (is_shift) begin
                    enc = {1'b0, funct7b5, 5'b0, imm[4:0], rs1, funct3, rd, op};
                    bad = |imm[11:5];
                end else begin
                    enc = {imm[11:0], rs1, funct3, rd, op};
                    bad = imm_ovf;
                end
            end
            OP_LD: begin
                enc = {imm[11:0], rs1, funct3, rd, op};
                bad = imm_ovf;
            end
            OP_S: begin
                enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
                bad = imm_ovf;
            end
            OP_B: begin
                enc = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
                bad = imm[0];
            end
            default: bad = 1'b1;
        endcase
    end

    assign in_ready = (state == ST_LOADING) && !clear;
    assign accept   = in_valid && in_ready;
    assign full     = (state == ST_FULL);

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        count_next = count;
        addr_next  = imem_addr;
        wdata_next = imem_wdata;
        we_next    = 1'b0;
        err_next   = 1'b0;
        if (clear) begin
            state_next = ST_LOADING;
            ptr_next   = BASE;
            count_next = '0;
        end else if (accept) begin
            if (bad) begin
                err_next = 1'b1;
            end else begin
                we_next    = 1'b1;
                addr_next  = ptr;
                wdata_next = enc;
                ptr_next   = ptr + ADDR_W'(1);
                count_next = count + (ADDR_W + 1)'(1);
                // Top address written: pointer wraps to 0 but stays parked until clear.
                if (ptr == TOP) state_next = ST_FULL;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_LOADING;
            ptr        <= BASE;
            count      <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            err        <= 1'b0;
        end else begin
            state      <= state_next;
            ptr        <= ptr_next;
            count      <= count_next;
            imem_we    <= we_next;
            imem_addr  <= addr_next;
            imem_wdata <= wdata_next;
            err        <= err_next;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: three instances (256 words, 4 words, 4 words from base 2)
// share stimulus and are compared against an arithmetic reference model.
module tb_instr_encoder;

    localparam logic [6:0] OP_R  = 7'h33;
    localparam logic [6:0] OP_I  = 7'h13;
    localparam logic [6:0] OP_LD = 7'h03;
    localparam logic [6:0] OP_S  = 7'h23;
    localparam logic [6:0] OP_B  = 7'h63;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        funct7b5;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [12:0] imm;

    logic        rdy [3];
    logic        we  [3];
    logic        er  [3];
    logic        fl  [3];
    logic [31:0] wd  [3];
    logic [7:0]  addr0;
    logic [1:0]  addr1, addr2;
    logic [8:0]  cnt0;
    logic [2:0]  cnt1, cnt2;

    int checks = 0;
    int errors = 0;

    // reference model state per instance
    int          depth [3] = '{256, 4, 4};
    int          base  [3] = '{0, 0, 2};
    int          m_ptr [3];
    int          m_cnt [3];
    logic        m_full[3];
    logic        e_we  [3];
    logic        e_err [3];
    logic        e_rdy [3];
    logic [31:0] e_addr[3];
    logic [31:0] e_wdata[3];

    // sampled DUT outputs
    logic        a_we  [3];
    logic        a_err [3];
    logic        a_full[3];
    logic        a_rdy [3];
    logic [31:0] a_addr[3];
    logic [31:0] a_cnt [3];
    logic [31:0] a_wdata[3];

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(rdy[0]),
        .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7b5(funct7b5), .imm(imm),
        .imem_we(we[0]), .imem_addr(addr0), .imem_wdata(wd[0]), .err(er[0]), .full(fl[0]), .count(cnt0)
    );

    instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut_s (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(rdy[1]),
        .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7b5(funct7b5), .imm(imm),
        .imem_we(we[1]), .imem_addr(addr1), .imem_wdata(wd[1]), .err(er[1]), .full(fl[1]), .count(cnt1)
    );

    instr_encoder #(.ADDR_W(2), .BASE_ADDR(2)) dut_b (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(rdy[2]),
        .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7b5(funct7b5), .imm(imm),
        .imem_we(we[2]), .imem_addr(addr2), .imem_wdata(wd[2]), .err(er[2]), .full(fl[2]), .count(cnt2)
    );

    // Encoding computed from the signed immediate value with plain integer arithmetic.
    function automatic logic [31:0] ref_encode(input logic [6:0] o, input logic [4:0] d,
                                               input logic [4:0] s1, input logic [4:0] s2,
                                               input logic [2:0] f3, input logic f7,
                                               input logic [12:0] im, output logic bad);
        int          iv;
        logic [31:0] rdf, s1f, s2f, f3f, w;
        iv = int'(im);
        if (iv >= 4096) iv = iv - 8192;
        rdf = 32'(d) << 7;
        s1f = 32'(s1) << 15;
        s2f = 32'(s2) << 20;
        f3f = 32'(f3) << 12;
        bad = 1'b0;
        w   = '0;
        case (o)
            OP_R: w = (32'(f7) << 30) | s2f | s1f | f3f | rdf | 32'(o);
            OP_I: begin
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    bad = (iv < 0) || (iv > 31);
                    w   = (32'(f7) << 30) | (32'(iv & 31) << 20) | s1f | f3f | rdf | 32'(o);
                end else begin
                    bad = (iv < -2048) || (iv > 2047);
                    w   = (32'(iv & 4095) << 20) | s1f | f3f | rdf | 32'(o);
                end
            end
            OP_LD: begin
                bad = (iv < -2048) || (iv > 2047);
                w   = (32'(iv & 4095) << 20) | s1f | f3f | rdf | 32'(o);
            end
            OP_S: begin
                bad = (iv < -2048) || (iv > 2047);
                w   = (32'((iv >>> 5) & 127) << 25) | s2f | s1f | f3f | (32'(iv & 31) << 7) | 32'(o);
            end
            OP_B: begin
                bad = (iv % 2) != 0;
                w   = (32'((iv >>> 12) & 1) << 31) | (32'((iv >>> 5) & 63) << 25) | s2f | s1f | f3f
                    | (32'((iv >>> 1) & 15) << 8) | (32'((iv >>> 11) & 1) << 7) | 32'(o);
            end
            default: bad = 1'b1;
        endcase
        return w;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_ptr[k]   = base[k];
            m_cnt[k]   = 0;
            m_full[k]  = 1'b0;
            e_we[k]    = 1'b0;
            e_err[k]   = 1'b0;
            e_addr[k]  = '0;
            e_wdata[k] = '0;
        end
    endtask

    task automatic model_step(input logic v, input logic clr);
        logic [31:0] w;
        logic        bad;
        w = ref_encode(op, rd, rs1, rs2, funct3, funct7b5, imm, bad);
        for (int k = 0; k < 3; k++) begin
            e_rdy[k] = !m_full[k] && !clr;
            e_we[k]  = 1'b0;
            e_err[k] = 1'b0;
            if (clr) begin
                m_ptr[k]  = base[k];
                m_cnt[k]  = 0;
                m_full[k] = 1'b0;
            end else if (v && e_rdy[k]) begin
                if (bad) begin
                    e_err[k] = 1'b1;
                end else begin
                    e_we[k]    = 1'b1;
                    e_addr[k]  = 32'(m_ptr[k]);
                    e_wdata[k] = w;
                    m_cnt[k]   = m_cnt[k] + 1;
                    if (m_ptr[k] == depth[k] - 1) begin
                        m_full[k] = 1'b1;
                        m_ptr[k]  = 0;
                    end else begin
                        m_ptr[k] = m_ptr[k] + 1;
                    end
                end
            end
        end
    endtask

    task automatic sample();
        for (int k = 0; k < 3; k++) begin
            a_we[k]    = we[k];
            a_err[k]   = er[k];
            a_full[k]  = fl[k];
            a_wdata[k] = wd[k];
        end
        a_addr[0] = 32'(addr0);
        a_addr[1] = 32'(addr1);
        a_addr[2] = 32'(addr2);
        a_cnt[0]  = 32'(cnt0);
        a_cnt[1]  = 32'(cnt1);
        a_cnt[2]  = 32'(cnt2);
    endtask

    task automatic set_fields(input logic [6:0] o, input logic [4:0] d, input logic [4:0] s1,
                              input logic [4:0] s2, input logic [2:0] f3, input logic f7,
                              input logic [12:0] im);
        op = o; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7b5 = f7; imm = im;
    endtask

    // Called just after a rising edge; ends 1 time unit after the next one.
    task automatic cycle(input logic v, input logic clr);
        in_valid = v;
        clear    = clr;
        #2;
        for (int k = 0; k < 3; k++) a_rdy[k] = rdy[k];
        model_step(v, clr);
        @(posedge clk);
        #1;
        sample();
    endtask

    task automatic apply_reset();
        in_valid = 1'b0;
        clear    = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        sample();
    endtask

    task automatic test_reset();
        in_valid = 1'b0;
        clear    = 1'b0;
        set_fields(OP_R, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 13'd0);
        #1 reset = 1'b1;
        #2;
        model_reset();
        sample();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (a_we[k] !== 1'b0 || a_err[k] !== 1'b0 || a_full[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_flags[%0d]: we=%b err=%b full=%b, want 0 0 0", k, a_we[k], a_err[k], a_full[k]);
            end
            checks++;
            if (a_addr[k] !== 32'd0 || a_wdata[k] !== 32'd0 || a_cnt[k] !== 32'd0) begin
                errors++;
                $display("FAIL reset_data[%0d]: addr=%0h wdata=%h count=%0d, want 0", k, a_addr[k], a_wdata[k], a_cnt[k]);
            end
        end
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rdy[k] !== 1'b1) begin
                errors++;
                $display("FAIL reset_ready[%0d]: got %b, want 1", k, rdy[k]);
            end
        end
    endtask

    task automatic test_add();
        apply_reset();
        set_fields(OP_R, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 13'd0);
        cycle(1'b1, 1'b0);
        checks++;
        if (a_we[0] !== 1'b1 || a_addr[0] !== 32'd0 || a_wdata[0] !== 32'h002081B3 || a_cnt[0] !== 32'd1) begin
            errors++;
            $display("FAIL add: we=%b addr=%0h wdata=%h count=%0d, want 1 0 002081b3 1", a_we[0], a_addr[0], a_wdata[0], a_cnt[0]);
        end
        cycle(1'b0, 1'b0);
        checks++;
        if (a_we[0] !== 1'b0 || a_cnt[0] !== 32'd1) begin
            errors++;
            $display("FAIL add_strobe_len: we=%b count=%0d, want 0 1", a_we[0], a_cnt[0]);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        set_fields(OP_R, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 13'd0);
        cycle(1'b1, 1'b0);
        checks++;
        if (a_we[0] !== 1'b1 || a_addr[0] !== 32'd0 || a_wdata[0] !== 32'h402081B3) begin
            errors++;
            $display("FAIL b2b_sub: we=%b addr=%0h wdata=%h, want 1 0 402081b3", a_we[0], a_addr[0], a_wdata[0]);
        end
        set_fields(OP_I, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 13'h1FFF);
        cycle(1'b1, 1'b0);
        checks++;
        if (a_we[0] !== 1'b1 || a_addr[0] !== 32'd1 || a_wdata[0] !== 32'hFFF00293 || a_cnt[0] !== 32'd2) begin
            errors++;
            $display("FAIL b2b_addi: we=%b addr=%0h wdata=%h count=%0d, want 1 1 fff00293 2", a_we[0], a_addr[0], a_wdata[0], a_cnt[0]);
        end
    endtask

    task automatic test_store_branch();
        set_fields(OP_S, 5'd0, 5'd1, 5'd2, 3'b010, 1'b0, 13'd8);
        cycle(1'b1, 1'b0);
        checks++;
        if (a_we[0] !== 1'b1 || a_addr[0] !== 32'd2 || a_wdata[0] !== 32'h0020A423) begin
            errors++;
            $display("FAIL sw: we=%b addr=%0h wdata=%h, want 1 2 0020a423", a_we[0], a_addr[0], a_wdata[0]);
        end
        set_fields(OP_B, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 13'h1FFC);
        cycle(1'b1, 1'b0);
        checks++;
        if (a_we[0] !== 1'b1 || a_addr[0] !== 32'd3 || a_wdata[0] !== 32'hFE208EE3) begin
            errors++;
            $display("FAIL beq: we=%b addr=%0h wdata=%h, want 1 3 fe208ee3", a_we[0], a_addr[0], a_wdata[0]);
        end
    endtask

    task automatic test_reject();
        logic [6:0]  ops  [3] = '{7'b0110111, OP_B, OP_I};
        logic [12:0] imms [3] = '{13'd0, 13'd3, 13'd2048};
        for (int i = 0; i < 3; i++) begin
            set_fields(ops[i], 5'd7, 5'd1, 5'd2, 3'd0, 1'b0, imms[i]);
            cycle(1'b1, 1'b0);
            checks++;
            if (a_err[0] !== 1'b1 || a_we[0] !== 1'b0 || a_cnt[0] !== 32'd4 || a_rdy[0] !== 1'b1) begin
                errors++;
                $display("FAIL reject[%0d]: err=%b we=%b count=%0d ready=%b, want 1 0 4 1", i, a_err[0], a_we[0], a_cnt[0], a_rdy[0]);
            end
        end
        set_fields(OP_R, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 13'd0);
        cycle(1'b1, 1'b0);
        checks++;
        if (a_err[0] !== 1'b0 || a_we[0] !== 1'b1 || a_addr[0] !== 32'd4 || a_cnt[0] !== 32'd5) begin
            errors++;
            $display("FAIL reject_resume: err=%b we=%b addr=%0h count=%0d, want 0 1 4 5", a_err[0], a_we[0], a_addr[0], a_cnt[0]);
        end
    endtask

    task automatic test_full();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            set_fields(OP_R, 5'(i + 1), 5'd1, 5'd2, 3'd0, 1'b0, 13'd0);
            cycle(1'b1, 1'b0);
            checks++;
            if (a_we[1] !== 1'b1 || a_addr[1] !== 32'(i) || a_cnt[1] !== 32'(i + 1) || a_full[1] !== 1'(i == 3)) begin
                errors++;
                $display("FAIL fill[%0d]: we=%b addr=%0h count=%0d full=%b, want 1 %0d %0d %0d", i, a_we[1], a_addr[1], a_cnt[1], a_full[1], i, i + 1, i == 3);
            end
        end
        checks++;
        if (a_full[2] !== 1'b1 || a_cnt[2] !== 32'd2 || rdy[1] !== 1'b0 || rdy[2] !== 1'b0) begin
            errors++;
            $display("FAIL full_state: base_full=%b base_count=%0d ready=%b/%b, want 1 2 0/0", a_full[2], a_cnt[2], rdy[1], rdy[2]);
        end
        cycle(1'b1, 1'b0);
        checks++;
        if (a_we[1] !== 1'b0 || a_rdy[1] !== 1'b0 || a_cnt[1] !== 32'd4 || a_full[1] !== 1'b1) begin
            errors++;
            $display("FAIL full_hold: we=%b ready=%b count=%0d full=%b, want 0 0 4 1", a_we[1], a_rdy[1], a_cnt[1], a_full[1]);
        end
        cycle(1'b1, 1'b1);
        checks++;
        if (a_rdy[0] !== 1'b0 || a_we[0] !== 1'b0 || a_we[1] !== 1'b0) begin
            errors++;
            $display("FAIL clear_blocks: ready=%b we=%b/%b, want 0 0/0", a_rdy[0], a_we[0], a_we[1]);
        end
        checks++;
        if (a_full[1] !== 1'b0 || a_cnt[1] !== 32'd0 || a_cnt[0] !== 32'd0 || a_cnt[2] !== 32'd0) begin
            errors++;
            $display("FAIL clear_state: full=%b counts=%0d/%0d/%0d, want 0 0/0/0", a_full[1], a_cnt[0], a_cnt[1], a_cnt[2]);
        end
        cycle(1'b1, 1'b0);
        checks++;
        if (a_we[1] !== 1'b1 || a_addr[1] !== 32'd0 || a_we[2] !== 1'b1 || a_addr[2] !== 32'd2) begin
            errors++;
            $display("FAIL clear_resume: we=%b/%b addr=%0h/%0h, want 1/1 0/2", a_we[1], a_we[2], a_addr[1], a_addr[2]);
        end
        // strobe from the previous acceptance stays visible while clear is high
        in_valid = 1'b0;
        clear    = 1'b1;
        #2;
        checks++;
        if (we[0] !== 1'b1 || addr0 !== 8'd0) begin
            errors++;
            $display("FAIL clear_inflight: we=%b addr=%0h, want 1 0", we[0], addr0);
        end
        model_step(1'b0, 1'b1);
        @(posedge clk);
        #1;
        sample();
        clear = 1'b0;
        checks++;
        if (a_we[0] !== 1'b0 || a_cnt[0] !== 32'd0) begin
            errors++;
            $display("FAIL clear_after: we=%b count=%0d, want 0 0", a_we[0], a_cnt[0]);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        set_fields(OP_R, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 13'd0);
        in_valid = 1'b1;
        clear    = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        sample();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (a_we[k] !== 1'b0 || a_err[k] !== 1'b0 || a_addr[k] !== 32'd0 || a_wdata[k] !== 32'd0 || a_cnt[k] !== 32'd0) begin
                errors++;
                $display("FAIL reset_mid[%0d]: we=%b err=%b addr=%0h wdata=%h count=%0d, want all 0", k, a_we[k], a_err[k], a_addr[k], a_wdata[k], a_cnt[k]);
            end
        end
        @(posedge clk);
        #1;
        sample();
        checks++;
        if (a_we[0] !== 1'b0 || a_we[2] !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: we=%b/%b, want 0/0", a_we[0], a_we[2]);
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        model_reset();
        cycle(1'b1, 1'b0);
        checks++;
        if (a_we[0] !== 1'b1 || a_addr[0] !== 32'd0 || a_we[2] !== 1'b1 || a_addr[2] !== 32'd2) begin
            errors++;
            $display("FAIL reset_resume: we=%b/%b addr=%0h/%0h, want 1/1 0/2", a_we[0], a_we[2], a_addr[0], a_addr[2]);
        end
    endtask

    task automatic test_random();
        logic [6:0]  o;
        logic [12:0] im;
        logic [2:0]  f3;
        int          sel;
        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 9);
            f3  = 3'($urandom);
            im  = ($urandom_range(0, 3) == 0) ? 13'($urandom) : {1'b0, 12'($urandom)};
            if (im[11] && !im[12] && $urandom_range(0, 1) == 1) im[12] = 1'b1;
            case (sel)
                0, 1: o = OP_R;
                2, 3: o = OP_I;
                4:    o = OP_LD;
                5:    o = OP_S;
                6, 7: o = OP_B;
                8: begin
                    o  = OP_I;
                    f3 = ($urandom_range(0, 1) == 1) ? 3'd1 : 3'd5;
                    im = ($urandom_range(0, 3) != 0) ? 13'($urandom_range(0, 31)) : 13'($urandom);
                end
                default: o = 7'($urandom);
            endcase
            // shift immediates keep bits 12 and 11 equal
            if (o == OP_I && (f3 == 3'd1 || f3 == 3'd5)) im[12] = im[11];
            set_fields(o, 5'($urandom), 5'($urandom), 5'($urandom), f3, 1'($urandom), im);
            cycle(1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 39) == 0));
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (a_rdy[k] !== e_rdy[k] || a_we[k] !== e_we[k] || a_err[k] !== e_err[k] || a_full[k] !== m_full[k]) begin
                    errors++;
                    $display("FAIL rand_ctrl[%0d] n=%0d: ready/we/err/full=%b%b%b%b, want %b%b%b%b", k, n, a_rdy[k], a_we[k], a_err[k], a_full[k], e_rdy[k], e_we[k], e_err[k], m_full[k]);
                end
                checks++;
                if (a_addr[k] !== e_addr[k] || a_wdata[k] !== e_wdata[k] || a_cnt[k] !== 32'(m_cnt[k])) begin
                    errors++;
                    $display("FAIL rand_data[%0d] n=%0d: addr=%0h wdata=%h count=%0d, want %0h %h %0d", k, n, a_addr[k], a_wdata[k], a_cnt[k], e_addr[k], e_wdata[k], m_cnt[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_store_branch();
        test_reject();
        test_full();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
